// File: rtl/p2s_pkg.sv
// p2s_pkg
// Shared definitions for the parallel-to-serial arbiter slice.
// Holds the two-state FSM encoding and the default requester count and
// word width used when p2s_arbiter is instantiated without overrides.
package p2s_pkg;

   localparam int N_REQ_DEFAULT = 4;
   localparam int WIDTH_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/p2s_arbiter_rr.sv
// rr_arbiter
// Purely combinational round-robin picker. The search begins one past the
// most recently granted index and wraps, so the requester that was just
// served has the lowest priority on the next pick.
// Ports:
//   req        in   N_REQ   request vector
//   last_grant in   IDX_W   index of the previous winner
//   grant      out  N_REQ   one-hot winner (all zero when nothing requests)
//   grant_idx  out  IDX_W   binary index of the winner
//   any        out  1       at least one request is present
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   // Walk the priority order starting at last_grant+1. The outer loop is the
   // priority rank, the inner loop finds the requester that holds that rank.
   // Once a winner is found every later rank is ignored, which keeps the
   // grant strictly one-hot.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && ((int'(last_grant) + k) % N_REQ == i)) begin
               any       = 1'b1;
               grant[i]  = 1'b1;
               grant_idx = i[IDX_W-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/p2s_arbiter.sv
// p2s_arbiter
// Collects parallel words from N_REQ requesters using round-robin
// arbitration and streams each one out serially, MSB first. A new word can
// be accepted on the last bit of the current one so consecutive words leave
// with no gap cycles.
// Ports:
//   clk          in   1              clock, rising edge
//   rst          in   1              synchronous active-high reset
//   en           in   1              advance enable, 0 freezes the serializer
//   req_valid    in   N_REQ          per-requester word available
//   req_data     in   N_REQ*WIDTH    packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready    out  N_REQ          one-hot accept strobe
//   dout         out  1              serial data
//   dout_valid   out  1              dout carries a valid bit
//   frame_start  out  1              marks the MSB of each word
//   ch_id        out  clog2(N_REQ)   requester owning the current word
//   busy         out  1              serializer is in SHIFT
module p2s_arbiter
   import p2s_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   dout,
   output logic                   dout_valid,
   output logic                   frame_start,
   output logic [IDX_W-1:0]       ch_id,
   output logic                   busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   shreg;
   logic [CNT_W-1:0]   bit_cnt;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   ch_reg;
   logic               held_bit;

   logic [N_REQ-1:0]   arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               grant_window;
   logic               accept;
   logic [WIDTH-1:0]   sel_word;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .grant_idx  (arb_idx),
      .any        (arb_any)
   );

   // A grant may only be issued when the serializer is free to take a word:
   // in IDLE, or on the final bit of the current word so the next one follows
   // without a gap. A stalled serializer or an active reset blocks all grants.
   always_comb begin
      grant_window = !rst && en && ((state == IDLE) || (bit_cnt == '0));
      req_ready    = grant_window ? arb_grant : '0;
      accept       = grant_window && arb_any;
   end

   // Pick the winner's word out of the packed bus using the one-hot grant, so
   // no multiply by a runtime index is needed.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_word = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Serial outputs come straight from the registered state. While stalled,
   // dout repeats the bit that was last presented rather than exposing the
   // next bit already sitting at the top of the shift register.
   always_comb begin
      busy        = (state == SHIFT);
      dout_valid  = busy && en;
      dout        = busy ? (en ? shreg[WIDTH-1] : held_bit) : 1'b0;
      frame_start = dout_valid && (bit_cnt == CNT_MAX);
      ch_id       = ch_reg;
   end

   // Main FSM. A captured word is copied into the shift register so later
   // changes on req_data cannot disturb it. Each enabled SHIFT cycle moves one
   // bit out; on the last bit the FSM either reloads from a new winner and
   // stays in SHIFT, or drops back to IDLE. Reset abandons any word in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= CNT_MAX;
         last_grant <= IDX_W'(N_REQ - 1);
         ch_reg     <= '0;
         held_bit   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg      <= sel_word;
                  bit_cnt    <= CNT_MAX;
                  last_grant <= arb_idx;
                  ch_reg     <= arb_idx;
                  held_bit   <= 1'b0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (en) begin
                  held_bit <= shreg[WIDTH-1];
                  if (bit_cnt == '0) begin
                     if (accept) begin
                        shreg      <= sel_word;
                        bit_cnt    <= CNT_MAX;
                        last_grant <= arb_idx;
                        ch_reg     <= arb_idx;
                     end else begin
                        shreg   <= '0;
                        bit_cnt <= CNT_MAX;
                        state   <= IDLE;
                     end
                  end else begin
                     shreg   <= {shreg[WIDTH-2:0], 1'b0};
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_p2s_arbiter.sv
// tb_p2s_arbiter
// Directed bench for p2s_arbiter with N_REQ=4, WIDTH=4. Inputs are driven
// 1ns after each rising edge and outputs sampled 1ns later, mid-cycle.
module tb_p2s_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        dout;
   logic        dout_valid;
   logic        frame_start;
   logic [1:0]  ch_id;
   logic        busy;

   int vectors;
   int miscompares;

   p2s_arbiter #(
      .N_REQ (4),
      .WIDTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .frame_start (frame_start),
      .ch_id       (ch_id),
      .busy        (busy)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Guard against the run stalling for any reason.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: time limit reached, actual=expired required=done");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic [3:0] v);
      rst       = r;
      en        = e;
      req_valid = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCheck(input string tag);
      #1;
      checkOutput({tag, " dout"}, dout, 1'b0);
      checkOutput({tag, " dout_valid"}, dout_valid, 1'b0);
      checkOutput({tag, " frame_start"}, frame_start, 1'b0);
      checkOutput({tag, " busy"}, busy, 1'b0);
   endtask

   task automatic acceptCheck(input string tag, input logic [3:0] expReady);
      #1;
      checkOutput({tag, " req_ready"}, req_ready, expReady);
      tick();
   endtask

   task automatic shiftWord(input string tag, input logic [3:0] word, input int ch,
                            input logic [3:0] readyAtLsb);
      for (int b = 3; b >= 0; b--) begin
         #1;
         checkOutput({tag, " dout"}, dout, word[b]);
         checkOutput({tag, " dout_valid"}, dout_valid, 1'b1);
         checkOutput({tag, " frame_start"}, frame_start, (b == 3));
         checkOutput({tag, " ch_id"}, ch_id, ch);
         checkOutput({tag, " busy"}, busy, 1'b1);
         if (b == 0) checkOutput({tag, " ready_at_lsb"}, req_ready, readyAtLsb);
         tick();
      end
   endtask

   initial begin
      logic [3:0] fairWords [4];
      logic       stallEn   [7];
      logic       stallBit  [7];
      logic [3:0] nextReady;

      fairWords = '{4'hA, 4'h5, 4'hC, 4'h3};
      stallEn   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      stallBit  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vectors     = 0;
      miscompares = 0;
      req_data    = '0;

      // Reset with requests pending: nothing may be granted.
      applyStimulus(1'b1, 1'b1, 4'b1111);
      tick();
      tick();
      idleCheck("reset");
      checkOutput("reset req_ready", req_ready, 4'b0000);
      checkOutput("reset ch_id", ch_id, 2'd0);

      // Single word from requester 0.
      applyStimulus(1'b0, 1'b1, 4'b0001);
      req_data[3:0] = 4'b1011;
      acceptCheck("single accept", 4'b0001);
      applyStimulus(1'b0, 1'b1, 4'b0000);
      shiftWord("single", 4'b1011, 0, 4'b0000);
      idleCheck("single idle");

      // Fairness: all requesters valid after a fresh reset.
      applyStimulus(1'b1, 1'b1, 4'b0000);
      tick();
      req_data = {4'h3, 4'hC, 4'h5, 4'hA};
      applyStimulus(1'b0, 1'b1, 4'b1111);
      acceptCheck("fair accept", 4'b0001);
      for (int w = 0; w < 5; w++) begin
         if (w == 4) begin
            req_valid = 4'b0000;
            nextReady = 4'b0000;
         end else begin
            nextReady = 4'b0001 << ((w + 1) % 4);
         end
         shiftWord($sformatf("fair w%0d", w), fairWords[w % 4], w % 4, nextReady);
      end
      idleCheck("fair idle");

      // en=0 in IDLE blocks the grant.
      req_data[3:0] = 4'b1100;
      applyStimulus(1'b0, 1'b0, 4'b0001);
      #1;
      checkOutput("idle en0 req_ready", req_ready, 4'b0000);
      tick();
      idleCheck("idle en0 still idle");

      // Stall mid-word: dout holds the last presented bit.
      applyStimulus(1'b0, 1'b1, 4'b0001);
      acceptCheck("stall accept", 4'b0001);
      req_valid = 4'b0000;
      for (int c = 0; c < 7; c++) begin
         en = stallEn[c];
         #1;
         checkOutput($sformatf("stall c%0d dout", c), dout, stallBit[c]);
         checkOutput($sformatf("stall c%0d dout_valid", c), dout_valid, stallEn[c]);
         checkOutput($sformatf("stall c%0d frame_start", c), frame_start, (c == 0));
         checkOutput($sformatf("stall c%0d busy", c), busy, 1'b1);
         tick();
      end
      en = 1'b1;
      idleCheck("stall idle");

      // Reset mid-word from requester 1; the pointer must return to 0.
      req_data[7:4] = 4'hF;
      applyStimulus(1'b0, 1'b1, 4'b0010);
      acceptCheck("rstmid accept", 4'b0010);
      req_valid = 4'b0000;
      for (int c = 0; c < 2; c++) begin
         #1;
         checkOutput("rstmid dout", dout, 1'b1);
         tick();
      end
      applyStimulus(1'b1, 1'b1, 4'b1111);
      #1;
      checkOutput("rstmid req_ready in reset", req_ready, 4'b0000);
      tick();
      req_data[3:0] = 4'b0110;
      applyStimulus(1'b0, 1'b1, 4'b1001);
      idleCheck("rstmid after");
      checkOutput("rstmid ch_id", ch_id, 2'd0);
      acceptCheck("rstmid regrant", 4'b0001);
      req_valid = 4'b0000;
      shiftWord("rstmid post", 4'b0110, 0, 4'b0000);
      idleCheck("rstmid idle");

      // Data isolation: requester 1 changes its word after acceptance.
      req_data[7:4] = 4'h9;
      applyStimulus(1'b0, 1'b1, 4'b0010);
      acceptCheck("iso accept", 4'b0010);
      req_data[7:4] = 4'h6;
      req_valid = 4'b0000;
      shiftWord("iso", 4'h9, 1, 4'b0000);
      idleCheck("iso idle");

      // Back-to-back words from requester 2 only.
      req_data[11:8] = 4'hF;
      applyStimulus(1'b0, 1'b1, 4'b0100);
      acceptCheck("b2b accept", 4'b0100);
      req_data[11:8] = 4'h0;
      shiftWord("b2b w0", 4'hF, 2, 4'b0100);
      req_valid = 4'b0000;
      shiftWord("b2b w1", 4'h0, 2, 4'b0000);
      idleCheck("b2b idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
